// File: rtl/nukv_pkg.sv
// Shared types and constants for the request join path.
// State encoding, meta field offsets, header magic and debug error codes.
package nukv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_PAD    = 3'd2,
        ST_KEY    = 3'd3,
        ST_VALUE  = 3'd4
    } state_t;

    localparam int OPCODE_HI = 95;
    localparam int KEYLEN_HI = 87;
    localparam int VALLEN_HI = 79;

    localparam logic [15:0] NET_MAGIC = 16'hFFFF;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_LAST  = 2'd2;

    localparam logic [7:0]  MAX_OPCODE = 8'd5;
    localparam logic [7:0]  MAX_KEYLEN = 8'd2;
    localparam logic [15:0] MAX_VALLEN = 16'd2000;

    function automatic logic range_error(input logic [7:0] opcode,
                                         input logic [7:0] keylen,
                                         input logic [15:0] vallen);
        return (opcode > MAX_OPCODE) || (keylen > MAX_KEYLEN) || (vallen > MAX_VALLEN);
    endfunction

endpackage

// File: rtl/nukv_value_serializer.sv
// Walks the 64-bit slices of one value word; the top decides when a word is consumed.
// restart returns the slice counter to 0 at the end of a request.
module nukv_value_serializer
    import nukv_pkg::*;
#(
    parameter int VALUE_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VALUE_WIDTH-1:0] value_data,
    input  logic                   step,
    input  logic                   restart,
    output logic [63:0]            slice_data,
    output logic                   last_slice
);

    localparam int SLICES  = VALUE_WIDTH / 64;
    localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;

    logic [SLICE_W-1:0] slice_q;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            slice_q <= '0;
        end else if (step) begin
            slice_q <= last_slice ? '0 : slice_q + 1'b1;
        end
    end

    assign last_slice = (int'(slice_q) == SLICES - 1);
    assign slice_data = value_data[int'(slice_q) * 64 +: 64];

endmodule

// File: rtl/nukv_request_join.sv
// Re-serialises meta/key/value streams into 128-bit network beats: header, pad, keys, value slices.
// Define NUKV_REQUEST_JOIN_ERRCHECK_EN to report range and last-mismatch errors on _debug[1:0].
module nukv_request_join
    import nukv_pkg::*;
#(
    parameter int META_WIDTH  = 96,
    parameter int VALUE_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [META_WIDTH-1:0]  meta_data,
    input  logic                   meta_valid,
    output logic                   meta_ready,
    input  logic [63:0]            key_data,
    input  logic                   key_valid,
    input  logic                   key_last,
    output logic                   key_ready,
    input  logic [VALUE_WIDTH-1:0] value_data,
    input  logic                   value_valid,
    input  logic                   value_last,
    output logic                   value_ready,
    output logic [127:0]           m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [3:0]             _debug
);

`ifdef NUKV_REQUEST_JOIN_ERRCHECK_EN
    localparam bit ERRCHECK = 1'b1;
`else
    localparam bit ERRCHECK = 1'b0;
`endif

    state_t       state_q, state_n;
    logic [7:0]   keylen_q, keylen_n, keyleft_q, keyleft_n;
    logic [15:0]  vallen_q, vallen_n, valleft_q, valleft_n;
    logic         pad_q, pad_n;
    logic [127:0] tdata_q, tdata_n;
    logic         tvalid_q, tvalid_n, tlast_q, tlast_n;
    logic [1:0]   err_q, err_n, dbg_state_q;
    logic         advance, ser_step, ser_restart, last_slice;
    logic [63:0]  slice_data;

    wire [7:0]  meta_opcode = meta_data[OPCODE_HI -: 8];
    wire [7:0]  meta_keylen = meta_data[KEYLEN_HI -: 8];
    wire [15:0] meta_vallen = meta_data[VALLEN_HI -: 16];

    assign advance = !tvalid_q || m_axis_tready;

    nukv_value_serializer #(.VALUE_WIDTH(VALUE_WIDTH)) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .value_data (value_data),
        .step       (ser_step),
        .restart    (ser_restart),
        .slice_data (slice_data),
        .last_slice (last_slice)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_n     = state_q;
        keylen_n    = keylen_q;
        vallen_n    = vallen_q;
        keyleft_n   = keyleft_q;
        valleft_n   = valleft_q;
        pad_n       = pad_q;
        tdata_n     = tdata_q;
        tvalid_n    = tvalid_q;
        tlast_n     = tlast_q;
        err_n       = ERR_NONE;
        meta_ready  = 1'b0;
        key_ready   = 1'b0;
        value_ready = 1'b0;
        ser_step    = 1'b0;
        ser_restart = 1'b0;

        if (advance && !rst) begin
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            case (state_q)
                // The header leaves with the meta handshake, so ST_HEADER is never resident.
                ST_IDLE: begin
                    meta_ready = 1'b1;
                    if (meta_valid) begin
                        keylen_n  = meta_keylen;
                        vallen_n  = meta_vallen;
                        keyleft_n = meta_keylen;
                        valleft_n = meta_vallen;
                        pad_n     = 1'b0;
                        tdata_n   = {meta_data[63:0], meta_opcode, meta_keylen,
                                     {8'h00, meta_keylen} + meta_vallen, 16'h0000, NET_MAGIC};
                        tvalid_n  = 1'b1;
                        state_n   = ST_PAD;
                        if (range_error(meta_opcode, meta_keylen, meta_vallen)) err_n = ERR_RANGE;
                    end
                end
                ST_PAD: begin
                    tdata_n  = '0;
                    tvalid_n = 1'b1;
                    if (keylen_q != 8'd0) begin
                        state_n = ST_KEY;
                    end else if (vallen_q != 16'd0) begin
                        state_n = ST_VALUE;
                    end else begin
                        tlast_n = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_KEY: begin
                    key_ready = !pad_q;
                    if (pad_q || key_valid) begin
                        tdata_n   = {64'h0, pad_q ? 64'h0 : key_data};
                        tvalid_n  = 1'b1;
                        keyleft_n = keyleft_q - 8'd1;
                        if (!pad_q && (key_last != (keyleft_q == 8'd1))) err_n = ERR_LAST;
                        if (!pad_q && key_last && (keyleft_q != 8'd1)) pad_n = 1'b1;
                        if (keyleft_q == 8'd1) begin
                            pad_n = 1'b0;
                            if (vallen_q == 16'd0) begin
                                tlast_n = 1'b1;
                                state_n = ST_IDLE;
                            end else begin
                                state_n = ST_VALUE;
                            end
                        end
                    end
                end
                ST_VALUE: begin
                    // A value word is consumed on its last used slice only.
                    value_ready = !pad_q && (last_slice || (valleft_q == 16'd1));
                    if (pad_q || value_valid) begin
                        tdata_n   = {64'h0, pad_q ? 64'h0 : slice_data};
                        tvalid_n  = 1'b1;
                        ser_step  = 1'b1;
                        valleft_n = valleft_q - 16'd1;
                        if (value_ready && (value_last != (valleft_q == 16'd1))) err_n = ERR_LAST;
                        if (value_ready && value_last && (valleft_q != 16'd1)) pad_n = 1'b1;
                        if (valleft_q == 16'd1) begin
                            pad_n       = 1'b0;
                            tlast_n     = 1'b1;
                            ser_restart = 1'b1;
                            state_n     = ST_IDLE;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            keylen_q    <= '0;
            vallen_q    <= '0;
            keyleft_q   <= '0;
            valleft_q   <= '0;
            pad_q       <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            err_q       <= ERR_NONE;
            dbg_state_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q     <= state_n;
            keylen_q    <= keylen_n;
            vallen_q    <= vallen_n;
            keyleft_q   <= keyleft_n;
            valleft_q   <= valleft_n;
            pad_q       <= pad_n;
            tdata_q     <= tdata_n;
            tvalid_q    <= tvalid_n;
            tlast_q     <= tlast_n;
            err_q       <= ERRCHECK ? err_n : ERR_NONE;
            dbg_state_q <= state_q[1:0];
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign _debug        = {dbg_state_q, err_q};

endmodule

// File: tb/tb_nukv_request_join.sv
// Self-checking bench for nukv_request_join: directed table, error and reset sequences,
// and randomized traffic with output stalls and source gaps against a beat-list model.
module tb_nukv_request_join;

    localparam int VW = 512;
    localparam int SL = VW / 64;

`ifdef NUKV_REQUEST_JOIN_ERRCHECK_EN
    localparam int EXP_ERR_PULSES = 1;
`else
    localparam int EXP_ERR_PULSES = 0;
`endif

    typedef struct packed { logic [127:0] data; logic last; } beat_t;
    typedef struct packed { logic [63:0] data; logic last; } key_t;
    typedef struct packed { logic [VW-1:0] data; logic last; } val_t;
    typedef struct packed {
        logic [7:0] op; logic [7:0] kl; logic [15:0] vl; logic [63:0] nm;
        int exp_len; int vr_count; int vr_first; int vr_last;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [95:0]    meta_data;
    logic           meta_valid, meta_ready;
    logic [63:0]    key_data;
    logic           key_valid, key_last, key_ready;
    logic [VW-1:0]  value_data;
    logic           value_valid, value_last, value_ready;
    logic [127:0]   m_axis_tdata;
    logic           m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [3:0]     dbg;

    nukv_request_join #(.META_WIDTH(96), .VALUE_WIDTH(VW)) dut (
        .clk           (clk),
        .rst           (rst),
        .meta_data     (meta_data),
        .meta_valid    (meta_valid),
        .meta_ready    (meta_ready),
        .key_data      (key_data),
        .key_valid     (key_valid),
        .key_last      (key_last),
        .key_ready     (key_ready),
        .value_data    (value_data),
        .value_valid   (value_valid),
        .value_last    (value_last),
        .value_ready   (value_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        ._debug        (dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] meta_q[$];
    key_t        key_q[$];
    val_t        val_q[$];
    beat_t       exp_q[$], act_q[$], prev_q[$], run_a[$];
    int          val_hs[$];
    int          key_hs, e1, e2;
    bit          hdr_pending, stalled_prev;
    logic [127:0] held_data;
    logic         held_last;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit coin(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    function automatic logic [63:0] key_word(input int rid, input int i);
        if (rid == 0) return 64'h11 + 64'(i);
        return {16'hCAFE, 16'(rid), 16'(i), 16'h4B45};
    endfunction

    function automatic logic [63:0] val_slice(input int rid, input int w, input int s);
        if (rid == 0) return 64'(w * SL + s + 1);
        return {16'hBEEF, 16'(rid), 16'(w), 16'(s)};
    endfunction

    // Reference model: a request is the beat list header, pad, keys, then value slices.
    task automatic add_request(input logic [7:0] op, input logic [7:0] kl, input logic [15:0] vl,
                               input logic [63:0] nm, input int rid);
        logic [VW-1:0] word;
        int nw;
        logic [15:0] total;
        total = 16'(int'(kl) + int'(vl));
        meta_q.push_back({op, kl, vl, nm});
        exp_q.push_back('{data: {nm, op, kl, total, 16'h0000, 16'hFFFF}, last: 1'b0});
        exp_q.push_back('{data: 128'h0, last: (kl == 8'd0 && vl == 16'd0)});
        for (int i = 0; i < int'(kl); i++) begin
            key_q.push_back('{data: key_word(rid, i), last: (i == int'(kl) - 1)});
            exp_q.push_back('{data: {64'h0, key_word(rid, i)},
                              last: (vl == 16'd0 && i == int'(kl) - 1)});
        end
        nw = (int'(vl) + SL - 1) / SL;
        for (int w = 0; w < nw; w++) begin
            for (int s = 0; s < SL; s++) word[s*64 +: 64] = val_slice(rid, w, s);
            val_q.push_back('{data: word, last: (w == nw - 1)});
        end
        for (int j = 0; j < int'(vl); j++)
            exp_q.push_back('{data: {64'h0, val_slice(rid, j / SL, j % SL)}, last: (j == int'(vl) - 1)});
    endtask

    task automatic step(input int stall_pct, input int gap_pct);
        @(negedge clk);
        meta_valid    = (meta_q.size() > 0) && !coin(gap_pct);
        meta_data     = (meta_q.size() > 0) ? meta_q[0] : '0;
        key_valid     = (key_q.size() > 0) && !coin(gap_pct);
        key_data      = (key_q.size() > 0) ? key_q[0].data : '0;
        key_last      = (key_q.size() > 0) ? key_q[0].last : 1'b0;
        value_valid   = (val_q.size() > 0) && !coin(gap_pct);
        value_data    = (val_q.size() > 0) ? val_q[0].data : '0;
        value_last    = (val_q.size() > 0) ? val_q[0].last : 1'b0;
        m_axis_tready = !coin(stall_pct);
        #1;
        if (hdr_pending) begin
            check("hdr_latency", 128'(m_axis_tvalid), 128'(1));
            hdr_pending = 1'b0;
        end
        if (stalled_prev) begin
            check("stall_tvalid", 128'(m_axis_tvalid), 128'(1));
            check("stall_tdata", m_axis_tdata, held_data);
            check("stall_tlast", 128'(m_axis_tlast), 128'(held_last));
        end
        if (m_axis_tvalid && m_axis_tready)
            act_q.push_back('{data: m_axis_tdata, last: m_axis_tlast});
        stalled_prev = m_axis_tvalid && !m_axis_tready;
        held_data    = m_axis_tdata;
        held_last    = m_axis_tlast;
        if (meta_valid && meta_ready) begin
            void'(meta_q.pop_front());
            hdr_pending = 1'b1;
        end
        if (key_valid && key_ready) begin
            void'(key_q.pop_front());
            key_hs++;
        end
        if (value_valid && value_ready) begin
            void'(val_q.pop_front());
            val_hs.push_back(act_q.size() + 1);
        end
        if (dbg[1:0] == 2'd1) e1++;
        if (dbg[1:0] == 2'd2) e2++;
    endtask

    task automatic run_pkts(input int stall_pct, input int gap_pct, input string tag, output int got);
        int n = 0;
        while (act_q.size() < exp_q.size() && n < 6000) begin
            step(stall_pct, gap_pct);
            n++;
        end
        repeat (4) step(0, 0);
        got = act_q.size();
        check({tag, " beats"}, 128'(act_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            check({tag, " data"}, act_q[i].data, exp_q[i].data);
            check({tag, " last"}, 128'(act_q[i].last), 128'(exp_q[i].last));
        end
        prev_q = act_q;
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, " tvalid"}, 128'(m_axis_tvalid), 128'(0));
        check({tag, " tlast"}, 128'(m_axis_tlast), 128'(0));
        check({tag, " tdata"}, m_axis_tdata, 128'(0));
        check({tag, " meta_ready"}, 128'(meta_ready), 128'(0));
        check({tag, " key_ready"}, 128'(key_ready), 128'(0));
        check({tag, " value_ready"}, 128'(value_ready), 128'(0));
        check({tag, " debug"}, 128'(dbg), 128'(0));
    endtask

    vec_t        vecs[6];
    logic [7:0]  r_op[12], r_kl[12];
    logic [15:0] r_vl[12];
    logic [63:0] r_nm[12];

    initial begin
        int got, n;
        vecs[0] = '{8'd1, 8'd1, 16'd3,  64'hA5,                  6,  1, 6,  6};
        vecs[1] = '{8'd2, 8'd2, 16'd10, 64'h1234_5678_9ABC_DEF0, 14, 2, 12, 14};
        vecs[2] = '{8'd3, 8'd1, 16'd0,  64'hDEAD_BEEF,           3,  0, 0,  0};
        vecs[3] = '{8'd4, 8'd0, 16'd0,  64'h0,                   2,  0, 0,  0};
        vecs[4] = '{8'd5, 8'd0, 16'd8,  64'hFFFF_FFFF_FFFF_FFFF, 10, 1, 10, 10};
        vecs[5] = '{8'd0, 8'd2, 16'd17, 64'h0123,                21, 3, 12, 21};

        rst = 1'b1;
        meta_data = '0; meta_valid = 1'b0;
        key_data = '0; key_valid = 1'b0; key_last = 1'b0;
        value_data = '0; value_valid = 1'b0; value_last = 1'b0;
        m_axis_tready = 1'b0;
        hdr_pending = 1'b0; stalled_prev = 1'b0;
        key_hs = 0; e1 = 0; e2 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed table, continuous tready.
        foreach (vecs[i]) begin
            val_hs.delete();
            add_request(vecs[i].op, vecs[i].kl, vecs[i].vl, vecs[i].nm, 0);
            run_pkts(0, 0, $sformatf("vec%0d", i), got);
            check($sformatf("vec%0d len", i), 128'(got), 128'(vecs[i].exp_len));
            check($sformatf("vec%0d vr_count", i), 128'(val_hs.size()), 128'(vecs[i].vr_count));
            if (vecs[i].vr_count > 0 && val_hs.size() > 0) begin
                check($sformatf("vec%0d vr_first", i), 128'(val_hs[0]), 128'(vecs[i].vr_first));
                check($sformatf("vec%0d vr_last", i), 128'(val_hs[val_hs.size()-1]), 128'(vecs[i].vr_last));
            end
        end

        // Early key_last: second key beat is zero padding and nothing more is consumed.
        key_hs = 0; e2 = 0;
        meta_q.push_back({8'd1, 8'd2, 16'd0, 64'h77});
        key_q.push_back('{data: 64'h77, last: 1'b1});
        exp_q.push_back('{data: {64'h77, 8'd1, 8'd2, 16'd2, 16'h0, 16'hFFFF}, last: 1'b0});
        exp_q.push_back('{data: 128'h0, last: 1'b0});
        exp_q.push_back('{data: {64'h0, 64'h77}, last: 1'b0});
        exp_q.push_back('{data: 128'h0, last: 1'b1});
        run_pkts(0, 0, "key_early", got);
        check("key_early consumed", 128'(key_hs), 128'(1));
        check("key_early err_pulse", 128'(e2), 128'(EXP_ERR_PULSES));

        // Out-of-range opcode reports a range error on acceptance.
        e1 = 0;
        add_request(8'd7, 8'd0, 16'd0, 64'h60, 60);
        run_pkts(0, 0, "range", got);
        check("range err_pulse", 128'(e1), 128'(EXP_ERR_PULSES));

        // Random traffic: once without stalls, then with stalls and source gaps.
        for (int r = 0; r < 12; r++) begin
            r_op[r] = 8'($urandom_range(0, 7));
            r_kl[r] = 8'($urandom_range(0, 3));
            r_vl[r] = 16'($urandom_range(0, 20));
            r_nm[r] = {$urandom, $urandom};
        end
        for (int r = 0; r < 12; r++) add_request(r_op[r], r_kl[r], r_vl[r], r_nm[r], r + 1);
        run_pkts(0, 0, "rand_nostall", got);
        run_a = prev_q;
        for (int r = 0; r < 12; r++) add_request(r_op[r], r_kl[r], r_vl[r], r_nm[r], r + 1);
        run_pkts(30, 20, "rand_stall", got);
        check("stall_vs_nostall len", 128'(prev_q.size()), 128'(run_a.size()));
        for (int i = 0; i < prev_q.size() && i < run_a.size(); i++)
            check("stall_vs_nostall beat", prev_q[i].data, run_a[i].data);

        // Reset in the middle of a packet, then a clean request.
        add_request(8'd1, 8'd1, 16'd3, 64'hA5, 0);
        n = 0;
        while (act_q.size() < 2 && n < 50) begin
            step(0, 0);
            n++;
        end
        check("midrst pre_beats", 128'(act_q.size()), 128'(2));
        @(negedge clk);
        rst = 1'b1;
        meta_valid = 1'b0; key_valid = 1'b0; value_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        meta_q.delete(); key_q.delete(); val_q.delete();
        exp_q.delete(); act_q.delete();
        hdr_pending = 1'b0; stalled_prev = 1'b0;
        add_request(8'd2, 8'd0, 16'd1, 64'h5EED, 51);
        run_pkts(0, 0, "post_rst", got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
